led_stack_gen: RTL and testbench

- Parametrised LED "stacking" pattern generator for the TM1638 board.
- A single lit dot enters at the entry end of a WIDTH-bit LED bar and travels one position per step. It lands on top of the already-stacked LEDs at the far end, then the next dot enters.
- When the bar is full, the bar either clears at once or drains one LED per step, selected by mode.
- Adds step-rate prescaling, run/pause, selectable direction, selectable end-of-fill mode, and status pulses. Sits between the system clock and the TM1638 LED driver input.

---
 rtl/led_stack_gen_pkg.sv | 20 ++
 rtl/led_stack_gen_if.sv | 14 +
 rtl/led_stack_gen_tick_div.sv | 25 ++
 rtl/led_stack_gen.sv | 133 +++++++++++++
 tb/tb_led_stack_gen.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/led_stack_gen_pkg.sv
// Shared types and constants for the TM1638 LED stacking pattern generator.
package led_pkg;

  // Animation phases: LOAD waits for the first tick of a sequence, MOVE walks
  // the dot and stacks it, DRAIN empties the full bar one LED per step.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MOVE  = 2'd1,
    DRAIN = 2'd2
  } led_st_e;

  // dir input encoding
  localparam logic DIR_MSB_ENTRY = 1'b0;  // dot enters at MSB, stacks at LSB
  localparam logic DIR_LSB_ENTRY = 1'b1;  // dot enters at LSB, stacks at MSB

  // mode input encoding
  localparam logic MODE_CLEAR = 1'b0;     // full bar clears in one step
  localparam logic MODE_DRAIN = 1'b1;     // full bar drains one LED per step

endpackage

// File: rtl/led_stack_gen_if.sv
// Control/status bundle between a pattern consumer and led_stack_gen.
interface led_stack_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] led;
  logic             step;
  logic             done;

  modport master (output en, dir, mode, input  led, step, done);
  modport slave  (input  en, dir, mode, output led, step, done);
endinterface

// File: rtl/led_stack_gen_tick_div.sv
// Step-rate prescaler: one tick every PRESC enabled clocks. The count is held
// (not cleared) while en is low, so resuming keeps the same phase.
module led_tick_div #(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rs_n,
  input  logic en,
  output logic tick
);
  localparam int              CNTW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(PRESC - 1);

  logic [CNTW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = en & w_wrap;

  // Free-running 0..PRESC-1 counter, advancing only while enabled.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n)   r_cnt <= '0;
    else if (en) r_cnt <= w_wrap ? '0 : r_cnt + CNTW'(1);
  end
endmodule

// File: rtl/led_stack_gen.sv
// LED stacking animation: a dot travels from the entry end and lands on the
// stack at the far end; a full bar is cleared or drained depending on mode.
module led_stack_gen
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRESC = 1,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rs_n,
  led_stack_gen_if.slave io_bus
);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] LSB1 = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB1 = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    KMAX = CW'(WIDTH - 1);

  // Single lit bit at the entry end for the given direction.
  function automatic logic [WIDTH-1:0] f_entry(input logic d);
    return (d == DIR_LSB_ENTRY) ? LSB1 : MSB1;
  endfunction

  // One position toward the stack side.
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] x, input logic d);
    return (d == DIR_LSB_ENTRY) ? (x << 1) : (x >> 1);
  endfunction

  led_st_e          r_st,   w_st_nxt;
  logic [WIDTH-1:0] r_z,    w_z_nxt;     // stacked LEDs
  logic [WIDTH-1:0] r_v,    w_v_nxt;     // travelling dot
  logic [CW-1:0]    r_k,    w_k_nxt;     // landing distance of current dot
  logic [CW-1:0]    r_n,    w_n_nxt;     // distance travelled so far
  logic             r_dirq, w_dirq_nxt;  // direction latched at LOAD
  logic [WIDTH-1:0] r_led;
  logic             r_step, r_done, w_done_nxt;
  logic             w_tick;
  logic [WIDTH-1:0] w_zsh;

  led_tick_div #(.PRESC(PRESC)) u_div (
    .clk  (clk),
    .rs_n (rs_n),
    .en   (io_bus.en),
    .tick (w_tick)
  );

  assign w_zsh = f_shift(r_z, r_dirq);

  // Registered state and outputs; led/step/done update together on the tick edge.
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      r_st   <= LOAD;
      r_z    <= '0;
      r_v    <= '0;
      r_k    <= KMAX;
      r_n    <= '0;
      r_dirq <= DIR_MSB_ENTRY;
      r_led  <= '0;
      r_step <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_z    <= w_z_nxt;
      r_v    <= w_v_nxt;
      r_k    <= w_k_nxt;
      r_n    <= w_n_nxt;
      r_dirq <= w_dirq_nxt;
      r_led  <= w_z_nxt | w_v_nxt;
      r_step <= w_tick;
      r_done <= w_done_nxt;
    end
  end

  // Next-state logic; everything holds unless a tick arrives.
  always_comb begin
    w_st_nxt   = r_st;
    w_z_nxt    = r_z;
    w_v_nxt    = r_v;
    w_k_nxt    = r_k;
    w_n_nxt    = r_n;
    w_dirq_nxt = r_dirq;
    w_done_nxt = 1'b0;
    if (w_tick) begin
      unique case (r_st)
        LOAD: begin
          w_dirq_nxt = io_bus.dir;
          w_v_nxt    = f_entry(io_bus.dir);
          w_n_nxt    = '0;
          w_st_nxt   = MOVE;
        end
        MOVE: begin
          if (r_n < r_k) begin
            w_v_nxt = f_shift(r_v, r_dirq);
            w_n_nxt = r_n + CW'(1);
          end else if (r_k != '0) begin
            // land and launch the next dot in the same step
            w_z_nxt = r_z | r_v;
            w_v_nxt = f_entry(r_dirq);
            w_k_nxt = r_k - CW'(1);
            w_n_nxt = '0;
          end else if (io_bus.mode == MODE_CLEAR) begin
            w_z_nxt    = '0;
            w_v_nxt    = '0;
            w_k_nxt    = KMAX;
            w_n_nxt    = '0;
            w_done_nxt = 1'b1;
            w_st_nxt   = LOAD;
          end else begin
            // the full-point step already removes the first entry-side LED,
            // so the drain finishes WIDTH steps after the bar fills
            w_z_nxt  = f_shift(ONES, r_dirq);
            w_v_nxt  = '0;
            w_st_nxt = DRAIN;
          end
        end
        DRAIN: begin
          w_z_nxt = w_zsh;
          if (w_zsh == '0) begin
            w_k_nxt    = KMAX;
            w_n_nxt    = '0;
            w_done_nxt = 1'b1;
            w_st_nxt   = LOAD;
          end
        end
        default: w_st_nxt = LOAD;
      endcase
    end
  end

  assign io_bus.led  = r_led;
  assign io_bus.step = r_step;
  assign io_bus.done = r_done;
endmodule

// File: tb/tb_led_stack_gen.sv
// Randomized bench: two instances (PRESC=1 and PRESC=4) share en/dir/mode and
// are compared every cycle against a frame-list model of the animation.
module tb_led_stack_gen;
  localparam int W    = 8;
  localparam int FILL = W * (W + 1) / 2;  // frames from first dot to full bar
  localparam int NCYC = 3000;
  localparam int RST_AT = 1500;

  logic clk = 1'b0;
  logic rs_n = 1'b0;
  logic en = 1'b0, dir = 1'b0, mode = 1'b0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  led_stack_gen_if #(.WIDTH(W)) if1 ();
  led_stack_gen_if #(.WIDTH(W)) if4 ();
  assign if1.en = en;  assign if1.dir = dir;  assign if1.mode = mode;
  assign if4.en = en;  assign if4.dir = dir;  assign if4.mode = mode;

  led_stack_gen #(.WIDTH(W), .PRESC(1)) u_dut1 (.clk(clk), .rs_n(rs_n), .io_bus(if1));
  led_stack_gen #(.WIDTH(W), .PRESC(4)) u_dut4 (.clk(clk), .rs_n(rs_n), .io_bus(if4));

  // model state, index 0 -> PRESC=1, index 1 -> PRESC=4
  int         P [2] = '{1, 4};
  int         m_idx [2];
  int         m_ecnt [2];
  logic       m_dir [2];
  logic [W-1:0] e_led [2];
  logic       e_step [2];
  logic       e_done [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame i of the fill phase: stack of height h at the far end plus a dot
  // that has travelled r positions from the entry end.
  function automatic logic [W-1:0] fill_frame(input int i, input logic d);
    int h = 0;
    int r = i;
    logic [W-1:0] f, g;
    while (r >= W - h) begin
      r -= W - h;
      h++;
    end
    f = W'((1 << h) - 1) | W'(1 << (W - 1 - r));
    g = '0;
    for (int b = 0; b < W; b++) g[b] = f[W-1-b];
    return d ? g : f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0; m_ecnt[d] = 0; m_dir[d] = 1'b0;
      e_led[d] = '0; e_step[d] = 1'b0; e_done[d] = 1'b0;
    end
  endtask

  // Predict outputs after the next rising edge from the inputs now applied.
  task automatic model_edge(input int d);
    logic [W-1:0] ones;
    int sh;
    ones = '1;
    e_step[d] = 1'b0;
    e_done[d] = 1'b0;
    if (en) begin
      m_ecnt[d]++;
      if (m_ecnt[d] == P[d]) begin
        m_ecnt[d] = 0;
        e_step[d] = 1'b1;
        if (m_idx[d] < FILL) begin
          if (m_idx[d] == 0) m_dir[d] = dir;
          e_led[d] = fill_frame(m_idx[d], m_dir[d]);
          m_idx[d]++;
        end else if (m_idx[d] == FILL && mode == 1'b0) begin
          e_led[d]  = '0;
          e_done[d] = 1'b1;
          m_idx[d]  = 0;
        end else begin
          sh = m_idx[d] - FILL + 1;
          e_led[d] = m_dir[d] ? (ones << sh) : (ones >> sh);
          if (e_led[d] == '0) begin
            e_done[d] = 1'b1;
            m_idx[d]  = 0;
          end else begin
            m_idx[d]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("led_p1",  32'(if1.led),  32'(e_led[0]));
    chk("step_p1", 32'(if1.step), 32'(e_step[0]));
    chk("done_p1", 32'(if1.done), 32'(e_done[0]));
    chk("led_p4",  32'(if4.led),  32'(e_led[1]));
    chk("step_p4", 32'(if4.step), 32'(e_step[1]));
    chk("done_p4", 32'(if4.done), 32'(e_done[1]));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();                         // reset state
    rs_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == RST_AT) begin
        // asynchronous reset between edges: outputs must clear at once
        #2 rs_n = 1'b0;
        #1;
        chk("arst_led_p1", 32'(if1.led), 32'd0);
        chk("arst_led_p4", 32'(if4.led), 32'd0);
        chk("arst_step_p1", 32'(if1.step), 32'd0);
        chk("arst_done_p4", 32'(if4.done), 32'd0);
        @(negedge clk);
        rs_n = 1'b1;
        model_reset();
      end
      if (cyc < 100) begin
        en = 1'b1; dir = 1'b0; mode = 1'b0;
      end else if (cyc < 200) begin
        en = 1'b1; dir = 1'b1; mode = 1'b0;
      end else if (cyc < 300) begin
        en = 1'b1; dir = 1'b0; mode = 1'b1;
      end else if (cyc >= 330 && cyc < 340) begin
        en = 1'b0;                       // frozen window
      end else begin
        en = ($urandom_range(7) != 0);
        if ($urandom_range(49) == 0) dir = ~dir;
        if ($urandom_range(49) == 0) mode = ~mode;
      end
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_all();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
